// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/acknowledge bundle between a requester and the iterative multiplier
interface seq_multiplier_if #(parameter int WIDTH = 8);
  logic en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic is_signed;
  logic [2*WIDTH-1:0] out;
  logic ack;
  logic busy;
  modport master (output en, a, b, is_signed, input out, ack, busy);
  modport slave (input en, a, b, is_signed, output out, ack, busy);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock, signed via magnitudes plus a final negate
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_q, acc_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, ack_q, ack_d;
  // the magnitude of the most negative value still fits unsigned in WIDTH bits
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    out_d = out_q;
    ack_d = 1'b0;
    case (state_q)
      IDLE: if (bus.en) begin
        mcand_d = a_mag;
        mplier_d = b_mag;
        neg_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        acc_d = '0;
        cnt_d = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : CALC;
      end
      DONE: begin
        out_d = neg_q ? -acc_q : acc_q;
        ack_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      out_q <= '0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      out_q <= out_d;
      ack_q <= ack_d;
    end
  end
  // the ack cycle is already IDLE but still counts as busy
  assign bus.busy = (state_q != IDLE) | ack_q;
  assign bus.out = out_q;
  assign bus.ack = ack_q;
endmodule
